// File: rtl/add8_err_pkg.sv
// Shared types, widths and the saturating adder used by the add8 error monitor.
package add8_err_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int ERR_W = 9;
    localparam int SQ_W  = 18;
    localparam int HDS_W = 4;

    // Adds inc to acc and clamps at 2**w-1; callers cast the result back to w bits.
    function automatic logic [63:0] sat_add(input logic [63:0] acc, input logic [63:0] inc, input int w);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, acc} + {1'b0, inc};
        lim = (65'd1 << w) - 65'd1;
        return (sum > lim) ? lim[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/add8_err_calc.sv
// Combinational error terms of an N-bit approximate adder against its exact sum.
module add8_err_calc #(
    parameter int N = 8
) (
    input  logic [N-1:0]               i_a,
    input  logic [N-1:0]               i_b,
    input  logic [N:0]                 i_o_apx,
    output logic [N:0]                 o_abs,
    output logic [2*N+1:0]             o_sq,
    output logic [$clog2(N+2)-1:0]     o_hd,
    output logic                       o_nz
);

    logic [N:0]   w_exact;
    logic [N+1:0] w_diff;
    logic [N+1:0] w_neg;

    assign w_exact = (N+1)'(i_a) + (N+1)'(i_b);
    // One extra bit keeps the difference signed; |diff| always fits in N+1 bits.
    assign w_diff  = {1'b0, i_o_apx} - {1'b0, w_exact};
    assign w_neg   = -w_diff;
    assign o_abs   = w_diff[N+1] ? w_neg[N:0] : w_diff[N:0];
    assign o_sq    = (2*N+2)'(o_abs) * (2*N+2)'(o_abs);
    assign o_hd    = ($clog2(N+2))'($countones(i_o_apx ^ w_exact));
    assign o_nz    = |o_abs;

endmodule

// File: rtl/add8_err_monitor.sv
// Run controller and saturating metric accumulators downstream of an 8-bit approximate adder.
module add8_err_monitor
    import add8_err_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int SAE_W = 42,
    parameter int SSE_W = 50,
    parameter int HD_W  = 38
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] sample_target,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       A,
    input  logic [7:0]       B,
    input  logic [8:0]       O_apx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] n_samples,
    output logic [CNT_W-1:0] n_err,
    output logic [SAE_W-1:0] sae,
    output logic [SSE_W-1:0] sse,
    output logic [ERR_W-1:0] wce,
    output logic [HD_W-1:0]  hd_sum
);

    // state | meaning
    // IDLE  | no run, in_ready low
    // RUN   | accepting until target samples taken
    // DRAIN | waiting for the last sample to reach the accumulators
    // DONE  | results stable, done high
    state_t             r_state;
    logic [CNT_W-1:0]   r_target;
    logic [CNT_W-1:0]   r_accepted;
    logic               r_in_ready;
    logic               r_busy;
    logic               r_done;

    logic               r_s1_valid;
    logic [ERR_W-1:0]   r_s1_abs;
    logic [SQ_W-1:0]    r_s1_sq;
    logic [HDS_W-1:0]   r_s1_hd;
    logic               r_s1_nz;

    logic [CNT_W-1:0]   r_n_samples;
    logic [CNT_W-1:0]   r_n_err;
    logic [SAE_W-1:0]   r_sae;
    logic [SSE_W-1:0]   r_sse;
    logic [ERR_W-1:0]   r_wce;
    logic [HD_W-1:0]    r_hd_sum;

    logic [ERR_W-1:0]   w_abs;
    logic [SQ_W-1:0]    w_sq;
    logic [HDS_W-1:0]   w_hd;
    logic               w_nz;
    logic               w_hs;
    logic [CNT_W-1:0]   w_accepted_nxt;
    logic               w_clear;
    logic               w_acc_en;

    add8_err_calc #(.N(8)) u_calc (
        .i_a     (A),
        .i_b     (B),
        .i_o_apx (O_apx),
        .o_abs   (w_abs),
        .o_sq    (w_sq),
        .o_hd    (w_hd),
        .o_nz    (w_nz)
    );

    assign w_hs           = in_valid & r_in_ready;
    assign w_accepted_nxt = r_accepted + CNT_W'(1);
    assign w_clear        = start & ~abort & ((r_state == IDLE) || (r_state == DONE));
    assign w_acc_en       = r_s1_valid & ~abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_target   <= '0;
            r_accepted <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_abs   <= '0;
            r_s1_sq    <= '0;
            r_s1_hd    <= '0;
            r_s1_nz    <= 1'b0;
        end else begin
            r_s1_valid <= w_hs & ~abort;
            if (w_hs) begin
                r_s1_abs <= w_abs;
                r_s1_sq  <= w_sq;
                r_s1_hd  <= w_hd;
                r_s1_nz  <= w_nz;
            end
            if (abort) begin
                r_state    <= IDLE;
                r_in_ready <= 1'b0;
                r_busy     <= 1'b0;
                r_done     <= 1'b0;
            end else begin
                case (r_state)
                    IDLE, DONE: begin
                        if (start) begin
                            r_state    <= (sample_target == '0) ? DRAIN : RUN;
                            r_target   <= sample_target;
                            r_accepted <= '0;
                            r_in_ready <= (sample_target != '0);
                            r_busy     <= 1'b1;
                            r_done     <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (w_hs) begin
                            r_accepted <= w_accepted_nxt;
                            if (w_accepted_nxt == r_target) begin
                                r_in_ready <= 1'b0;
                                r_state    <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        if (!r_s1_valid) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n_samples <= '0;
            r_n_err     <= '0;
            r_sae       <= '0;
            r_sse       <= '0;
            r_wce       <= '0;
            r_hd_sum    <= '0;
        end else if (w_clear) begin
            r_n_samples <= '0;
            r_n_err     <= '0;
            r_sae       <= '0;
            r_sse       <= '0;
            r_wce       <= '0;
            r_hd_sum    <= '0;
        end else if (w_acc_en) begin
            r_n_samples <= CNT_W'(sat_add(64'(r_n_samples), 64'd1, CNT_W));
            r_n_err     <= CNT_W'(sat_add(64'(r_n_err), 64'(r_s1_nz), CNT_W));
            r_sae       <= SAE_W'(sat_add(64'(r_sae), 64'(r_s1_abs), SAE_W));
            r_sse       <= SSE_W'(sat_add(64'(r_sse), 64'(r_s1_sq), SSE_W));
            r_hd_sum    <= HD_W'(sat_add(64'(r_hd_sum), 64'(r_s1_hd), HD_W));
            if (r_s1_abs > r_wce) begin
                r_wce <= r_s1_abs;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign n_samples = r_n_samples;
    assign n_err     = r_n_err;
    assign sae       = r_sae;
    assign sse       = r_sse;
    assign wce       = r_wce;
    assign hd_sum    = r_hd_sum;

endmodule

// File: tb/tb_add8_err_monitor.sv
// Randomized self-checking bench for add8_err_monitor against a sum-of-errors reference model.
module tb_add8_err_monitor;

    localparam int CNT_W = 16;
    localparam int SAE_W = 12;
    localparam int SSE_W = 20;
    localparam int HD_W  = 8;
    localparam int TOT_W = 2*CNT_W + SAE_W + SSE_W + 9 + HD_W;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] sample_target = '0;
    logic             in_valid = 1'b0;
    logic [7:0]       A = '0;
    logic [7:0]       B = '0;
    logic [8:0]       O_apx = '0;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] n_samples;
    logic [CNT_W-1:0] n_err;
    logic [SAE_W-1:0] sae;
    logic [SSE_W-1:0] sse;
    logic [8:0]       wce;
    logic [HD_W-1:0]  hd_sum;
    logic [TOT_W-1:0] got_vec;

    add8_err_monitor #(.CNT_W(CNT_W), .SAE_W(SAE_W), .SSE_W(SSE_W), .HD_W(HD_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .sample_target(sample_target),
        .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .O_apx(O_apx),
        .busy(busy), .done(done), .n_samples(n_samples), .n_err(n_err), .sae(sae),
        .sse(sse), .wce(wce), .hd_sum(hd_sum)
    );

    always #5 clk = ~clk;

    assign got_vec = {n_samples, n_err, sae, sse, wce, hd_sum};

    typedef struct { logic [7:0] a; logic [7:0] b; logic [8:0] o; } smp_t;
    smp_t q[$];
    smp_t saved[$];

    int n_cmp = 0;
    int n_fail = 0;
    longint m_ns, m_ne, m_sae, m_sse, m_wce, m_hd;

    function automatic void model_clear();
        m_ns = 0; m_ne = 0; m_sae = 0; m_sse = 0; m_wce = 0; m_hd = 0;
    endfunction

    function automatic void model_accept(input logic [7:0] a, input logic [7:0] b, input logic [8:0] o);
        int ex;
        int e;
        ex = int'(a) + int'(b);
        e = int'(o) - ex;
        if (e < 0) e = -e;
        m_ns++;
        if (e != 0) m_ne++;
        m_sae += e;
        m_sse += longint'(e) * longint'(e);
        if (e > m_wce) m_wce = e;
        m_hd += $countones(o ^ 9'(ex));
    endfunction

    function automatic longint satv(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [TOT_W-1:0] model_vec();
        return {CNT_W'(satv(m_ns, CNT_W)), CNT_W'(satv(m_ne, CNT_W)), SAE_W'(satv(m_sae, SAE_W)),
                SSE_W'(satv(m_sse, SSE_W)), 9'(m_wce), HD_W'(satv(m_hd, HD_W))};
    endfunction

    function automatic void push(input logic [7:0] a, input logic [7:0] b, input logic [8:0] o);
        smp_t s;
        s.a = a; s.b = b; s.o = o;
        q.push_back(s);
    endfunction

    function automatic void push_random(input int n);
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] ex;
        logic [8:0] o;
        for (int i = 0; i < n; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            ex = 9'(a) + 9'(b);
            case ($urandom_range(0, 3))
                0: o = ex;
                1: o = ex ^ 9'($urandom_range(0, 15));
                2: o = 9'($urandom);
                default: o = {ex[8:3], 3'b000};
            endcase
            push(a, b, o);
        end
    endfunction

    task automatic do_start(input int t);
        @(negedge clk);
        sample_target = CNT_W'(t);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_clear();
    endtask

    // Returns at the negedge just before the edge that accepts the final queued sample.
    task automatic feed(input bit gaps, output bit ok);
        int budget;
        budget = 2000;
        while (q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
            A = q[0].a;
            B = q[0].b;
            O_apx = q[0].o;
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (in_valid && in_ready) begin
                model_accept(q[0].a, q[0].b, q[0].o);
                void'(q.pop_front());
            end
        end
        ok = (q.size() == 0);
        q.delete();
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (got_vec !== '0) begin n_fail++; $display("FAIL reset_metrics got %h exp 0", got_vec); end
        n_cmp++;
        if ({in_ready, busy, done} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl got %b exp 000", {in_ready, busy, done}); end
        in_valid = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({in_ready, busy, n_samples} !== {2'b00, CNT_W'(0)}) begin
            n_fail++; $display("FAIL idle_ignores_valid got rdy=%b busy=%b ns=%0d exp 0 0 0", in_ready, busy, n_samples);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_exact();
        bit ok;
        push(8'h10, 8'h20, 9'h030);
        push(8'hFF, 8'h01, 9'h100);
        push(8'h00, 8'h00, 9'h000);
        do_start(3);
        feed(1'b0, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL exact_feed timeout got %0d left exp 0", q.size()); end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL exact_lat1 got busy/done=%b exp 10", {busy, done}); end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL exact_lat2 got done=%b exp 0", done); end
        @(negedge clk);
        n_cmp++;
        if ({busy, done} !== 2'b01) begin n_fail++; $display("FAIL exact_lat3 got busy/done=%b exp 01", {busy, done}); end
        n_cmp++;
        if (got_vec !== model_vec()) begin n_fail++; $display("FAIL exact_totals got %h exp %h", got_vec, model_vec()); end
        n_cmp++;
        if ({n_samples, n_err, sae} !== {CNT_W'(3), CNT_W'(0), SAE_W'(0)}) begin
            n_fail++; $display("FAIL exact_const got ns=%0d ne=%0d sae=%0d exp 3 0 0", n_samples, n_err, sae);
        end
    endtask

    task automatic test_errors();
        bit ok;
        int rdy_hi;
        push(8'hFF, 8'hFF, 9'h1F0);
        push(8'h01, 8'h02, 9'h007);
        do_start(2);
        feed(1'b0, ok);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(20, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL errors_done timeout got done=%b exp 1", done); end
        n_cmp++;
        if ({n_samples, n_err, sae, sse, wce, hd_sum} !== {CNT_W'(2), CNT_W'(2), SAE_W'(18), SSE_W'(212), 9'd14, HD_W'(4)}) begin
            n_fail++; $display("FAIL errors_const got ns=%0d ne=%0d sae=%0d sse=%0d wce=%0d hd=%0d exp 2 2 18 212 14 4",
                               n_samples, n_err, sae, sse, wce, hd_sum);
        end
        n_cmp++;
        if (got_vec !== model_vec()) begin n_fail++; $display("FAIL errors_model got %h exp %h", got_vec, model_vec()); end
        in_valid = 1'b1;
        A = 8'h55; B = 8'h0F; O_apx = 9'h000;
        rdy_hi = 0;
        repeat (4) begin
            @(negedge clk);
            if (in_ready) rdy_hi++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (rdy_hi !== 0 || done !== 1'b1 || got_vec !== model_vec()) begin
            n_fail++; $display("FAIL done_hold got rdy_cycles=%0d done=%b vec=%h exp 0 1 %h", rdy_hi, done, got_vec, model_vec());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int rdy_hi;
        push_random(4);
        saved = q;
        do_start(4);
        feed(1'b0, ok);
        @(negedge clk);
        rdy_hi = 0;
        repeat (6) begin
            if (in_ready) rdy_hi++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_done(20, ok);
        n_cmp++;
        if (rdy_hi !== 0 || !ok) begin n_fail++; $display("FAIL bp_ready_after got rdy_cycles=%0d done=%b exp 0 1", rdy_hi, ok); end
        n_cmp++;
        if (n_samples !== CNT_W'(4)) begin n_fail++; $display("FAIL bp_count got %0d exp 4", n_samples); end
        n_cmp++;
        if (got_vec !== model_vec()) begin n_fail++; $display("FAIL bp_totals got %h exp %h", got_vec, model_vec()); end
        q = saved;
        do_start(4);
        feed(1'b1, ok);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(20, ok);
        n_cmp++;
        if (!ok || got_vec !== model_vec()) begin
            n_fail++; $display("FAIL bp_gaps_totals got %h done=%b exp %h", got_vec, ok, model_vec());
        end
    endtask

    task automatic test_random();
        bit ok;
        push_random(20);
        do_start(40);
        feed(1'b1, ok);
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || n_samples !== CNT_W'(20)) begin
            n_fail++; $display("FAIL run_start_ignored got busy=%b ns=%0d exp 1 20", busy, n_samples);
        end
        push_random(20);
        feed(1'b1, ok);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(20, ok);
        n_cmp++;
        if (!ok || got_vec !== model_vec()) begin
            n_fail++; $display("FAIL random_totals got %h done=%b exp %h", got_vec, ok, model_vec());
        end
    endtask

    task automatic test_saturation();
        bit ok;
        for (int i = 0; i < 20; i++) push(8'h00, 8'h00, 9'h1FF);
        do_start(20);
        feed(1'b0, ok);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(20, ok);
        n_cmp++;
        if (!ok || got_vec !== model_vec()) begin
            n_fail++; $display("FAIL sat_totals got %h done=%b exp %h", got_vec, ok, model_vec());
        end
        n_cmp++;
        if (sae !== {SAE_W{1'b1}} || sse !== {SSE_W{1'b1}} || wce !== 9'd511) begin
            n_fail++; $display("FAIL sat_pinned got sae=%h sse=%h wce=%0d exp all-ones all-ones 511", sae, sse, wce);
        end
    endtask

    task automatic test_zero_target();
        bit ok;
        do_start(0);
        n_cmp++;
        if ({busy, in_ready} !== 2'b10) begin n_fail++; $display("FAIL zero_drain got busy/rdy=%b exp 10", {busy, in_ready}); end
        wait_done(10, ok);
        n_cmp++;
        if (!ok || got_vec !== '0) begin n_fail++; $display("FAIL zero_done got %h done=%b exp 0 1", got_vec, ok); end
    endtask

    task automatic test_abort();
        bit ok;
        do_start(5);
        push_random(2);
        feed(1'b0, ok);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy got %b exp 1", busy); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if ({busy, done, in_ready} !== 3'b000) begin n_fail++; $display("FAIL abort_idle got %b exp 000", {busy, done, in_ready}); end
        n_cmp++;
        if (n_samples !== CNT_W'(2) || got_vec !== model_vec()) begin
            n_fail++; $display("FAIL abort_hold got %h exp %h", got_vec, model_vec());
        end
        sample_target = CNT_W'(5);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || got_vec !== model_vec()) begin
            n_fail++; $display("FAIL abort_wins got busy=%b vec=%h exp 0 %h", busy, got_vec, model_vec());
        end
        do_start(5);
        n_cmp++;
        if (busy !== 1'b1 || got_vec !== '0) begin n_fail++; $display("FAIL restart_clear got busy=%b vec=%h exp 1 0", busy, got_vec); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_reset_midrun();
        bit ok;
        push_random(3);
        do_start(10);
        feed(1'b0, ok);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (got_vec !== '0 || {in_ready, busy, done} !== 3'b000) begin
            n_fail++; $display("FAIL rst_midrun got vec=%h ctrl=%b exp 0 000", got_vec, {in_ready, busy, done});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (got_vec !== '0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_flush got vec=%h busy=%b exp 0 0", got_vec, busy);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_exact();
        test_errors();
        test_backpressure();
        test_random();
        test_saturation();
        test_zero_target();
        test_abort();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
